l1_l2_arbiter: RTL
==================

Name: l1_l2_arbiter

Overview:
- Shares the single L2 request port between the L1 instruction cache (read refills only) and the L1 data cache (refills and dirty write-backs).
- Sits between both L1 controllers and L2.
- Round-robin arbitration; latches each granted command for the whole transaction.
- Routes the L2 ready pulse and line data back to the owning requester.
- Swallows the response of an L1I transaction that is flushed mid-flight.

Parameters:
TAG_W, 18, L2 tag width
INDEX_W, 8, L2 set index width
LINE_W, 512, cache line width in bits

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
read_L1I_L2  input  1  L1I refill request, held until its ready
tag_L1I_L2  input  TAG_W  L1I request tag
index_L1I_L2  input  INDEX_W  L1I request index
flush_I  input  1  L1I pipeline flush
ready_L2_L1I  output  1  one-cycle completion pulse to L1I
read_data_L2_L1I  output  LINE_W  refill line to L1I
read_L1D_L2  input  1  L1D refill request, held until its ready
write_L1D_L2  input  1  L1D write-back request, held until its ready
tag_L1D_L2  input  TAG_W  L1D request tag
index_L1D_L2  input  INDEX_W  L1D request index
write_data_L1D_L2  input  LINE_W  write-back line, stable while write_L1D_L2 is high
ready_L2_L1D  output  1  one-cycle completion pulse to L1D
read_data_L2_L1D  output  LINE_W  refill line to L1D
read_L1_L2  output  1  read command to L2
write_L1_L2  output  1  write command to L2
tag_L1_L2  output  TAG_W  latched tag
index_L1_L2  output  INDEX_W  latched index
write_data_L1_L2  output  LINE_W  write data to L2
ready_L2_L1  input  1  L2 completion pulse
read_data_L2_L1  input  LINE_W  L2 line data, valid with ready_L2_L1
grant_cnt_I  output  16  L1I grant count (optional feature)
grant_cnt_D  output  16  L1D grant count (optional feature)

Behaviour:
- Reset (async, nrst low):
  - State IDLE, last_grant=D, so L1I wins the first tie.
  - All command, ready and tag/index outputs 0. Data outputs 0.
  - Swallow flag cleared. Counters 0.
- States: IDLE, BUSY_I, BUSY_D, GAP.
- IDLE:
  - reqI = read_L1I_L2 & ~flush_I.
  - reqD = read_L1D_L2 | write_L1D_L2.
  - Only one request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - On grant: latch tag, index and command, update last_grant, go to BUSY_x.
  - L1D command: write if write_L1D_L2 is high, else read. Both high is illegal; write wins.
- BUSY_x:
  - read_L1_L2/write_L1_L2 driven from the latched command, starting the cycle after the grant decision. Latency to L2 is 1 cycle.
  - Tag and index come from latches. write_data_L1_L2 muxes write_data_L1D_L2 in BUSY_D with a write command, else 0.
  - On ready_L2_L1: drop the L2 command the same cycle (combinational off the ready pulse), pulse the owner's ready output that cycle, go to GAP.
  - read_data_L2_L1 is passed combinationally to the owner's read_data output. The non-owner's data output is 0.
- GAP:
  - Exactly one cycle, no grant, so the requester can deassert its held request.
  - Then return to IDLE.
- Flush:
  - flush_I during BUSY_I sets the swallow flag. The L2 transaction still completes.
  - ready_L2_L1I is suppressed on completion. The flag clears in GAP.
  - flush_I in IDLE masks reqI that cycle only.
  - flush_I has no effect on BUSY_D.
- Simultaneous cases:
  - A request arriving the same cycle as ready_L2_L1 is not granted until IDLE.
  - ready_L2_L1 in IDLE or GAP is ignored; no pulse is forwarded.
- Reset mid-transaction returns to IDLE immediately. No response is forwarded.

Optional Feature:
- L1_L2_ARB_PERF_CNT_EN defined:
  - grant_cnt_I/grant_cnt_D increment on each grant to that requester.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Macro undefined: both ports tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package l1_l2_pkg:
  - TAG_W/INDEX_W/LINE_W defaults.
  - State enum {IDLE, BUSY_I, BUSY_D, GAP}.
  - Requester id constants REQ_I=0, REQ_D=1.
- One natural sub-module, l1_l2_rr_pick: a 2-way round-robin picker taking reqI, reqD and last_grant, returning grant one-hot.

Test Plan:
- Single L1I read, tag 18'h1A2B3, index 8'h45:
  - read_L1_L2 rises the next cycle with the latched tag and index.
  - L2 ready after 5 cycles with data 512'hA5.. gives ready_L2_L1I=1 for one cycle with that data, then GAP, then IDLE.
- L1I and L1D requests in the same cycle from reset:
  - L1I is granted first. L1D is granted in the IDLE following GAP.
  - A repeat conflict grants L1D first.
- L1D write-back, write_data 512'h5A..:
  - write_L1_L2=1 and read_L1_L2=0, with write_data_L1_L2 matching.
  - ready_L2_L1D pulses on completion.
- flush_I during BUSY_I:
  - L2 still sees its command until ready.
  - ready_L2_L1I stays 0; ready_L2_L1D stays 0.
  - A new L1I request is accepted after GAP.
- nrst low mid-BUSY_D: all outputs are 0 the same cycle, no ready is forwarded, and the next grant follows reset priority (L1I).
- With L1_L2_ARB_PERF_CNT_EN: 3 L1I and 2 L1D grants give grant_cnt_I=3 and grant_cnt_D=2. Without the macro, both counters read 0.

Source files
------------

// File: rtl/l1_l2_pkg.sv
// +----------------------------------------------------------------------+
// | Package  : l1_l2_pkg                                                 |
// | Purpose  : Shared widths, arbiter state encoding and requester ids   |
// |            for the L1I/L1D to L2 arbiter slice.                      |
// | Contents : DEF_TAG_W / DEF_INDEX_W / DEF_LINE_W default widths,      |
// |            arb_state_e {IDLE, BUSY_I, BUSY_D, GAP},                  |
// |            REQ_I / REQ_D requester ids (also grant one-hot indices). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package l1_l2_pkg;

  localparam int DEF_TAG_W   = 18;
  localparam int DEF_INDEX_W = 8;
  localparam int DEF_LINE_W  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  // Requester ids; also the bit positions in the grant one-hot vector.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/l1_l2_rr_pick.sv
// +----------------------------------------------------------------------+
// | Module   : l1_l2_rr_pick                                             |
// | Purpose  : Two-way round-robin picker between L1I and L1D requests.  |
// |            On a tie the requester that did not win last time wins.   |
// | Ports    : req_l1i_i    - L1I request (already flush-masked)         |
// |            req_l1d_i    - L1D request (read or write-back)           |
// |            last_grant_i - id of the most recent winner (REQ_I/REQ_D) |
// |            grant_o      - one-hot grant, indexed by REQ_I / REQ_D    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module l1_l2_rr_pick
  import l1_l2_pkg::*;
(
  input  logic       req_l1i_i,
  input  logic       req_l1d_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o        = 2'b00;
    grant_o[REQ_I] = req_l1i_i & (~req_l1d_i | (last_grant_i == REQ_D));
    grant_o[REQ_D] = req_l1d_i & (~req_l1i_i | (last_grant_i == REQ_I));
  end

endmodule

`default_nettype wire

// File: rtl/l1_l2_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : l1_l2_arbiter                                             |
// | Purpose  : Shares the single L2 request port between the L1I (refill |
// |            reads) and the L1D (refills and dirty write-backs).       |
// |            Round-robin grant, command/tag/index latched for the whole|
// |            transaction, L2 ready/data routed back to the owner, and  |
// |            the response of a flushed L1I transaction swallowed.      |
// | Ports    : clk, nrst (async, active low)                             |
// |            L1I side : read_L1I_L2, tag_L1I_L2, index_L1I_L2, flush_I,|
// |                       ready_L2_L1I, read_data_L2_L1I                 |
// |            L1D side : read_L1D_L2, write_L1D_L2, tag_L1D_L2,         |
// |                       index_L1D_L2, write_data_L1D_L2,               |
// |                       ready_L2_L1D, read_data_L2_L1D                 |
// |            L2 side  : read_L1_L2, write_L1_L2, tag_L1_L2,            |
// |                       index_L1_L2, write_data_L1_L2, ready_L2_L1,    |
// |                       read_data_L2_L1                                |
// |            Perf     : grant_cnt_I, grant_cnt_D                       |
// | Macro    : L1_L2_ARB_PERF_CNT_EN - enables saturating 16-bit grant   |
// |            counters; when undefined both counter ports read 0.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module l1_l2_arbiter
  import l1_l2_pkg::*;
#(
  parameter int TAG_W   = DEF_TAG_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int LINE_W  = DEF_LINE_W
) (
  input  logic               clk,
  input  logic               nrst,
  // L1I
  input  logic               read_L1I_L2,
  input  logic [TAG_W-1:0]   tag_L1I_L2,
  input  logic [INDEX_W-1:0] index_L1I_L2,
  input  logic               flush_I,
  output logic               ready_L2_L1I,
  output logic [LINE_W-1:0]  read_data_L2_L1I,
  // L1D
  input  logic               read_L1D_L2,
  input  logic               write_L1D_L2,
  input  logic [TAG_W-1:0]   tag_L1D_L2,
  input  logic [INDEX_W-1:0] index_L1D_L2,
  input  logic [LINE_W-1:0]  write_data_L1D_L2,
  output logic               ready_L2_L1D,
  output logic [LINE_W-1:0]  read_data_L2_L1D,
  // L2
  output logic               read_L1_L2,
  output logic               write_L1_L2,
  output logic [TAG_W-1:0]   tag_L1_L2,
  output logic [INDEX_W-1:0] index_L1_L2,
  output logic [LINE_W-1:0]  write_data_L1_L2,
  input  logic               ready_L2_L1,
  input  logic [LINE_W-1:0]  read_data_L2_L1,
  // Performance counters
  output logic [15:0]        grant_cnt_I,
  output logic [15:0]        grant_cnt_D
);

  arb_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               cmd_wr_q, cmd_wr_d;
  logic               swallow_q, swallow_d;

  logic               req_l1i;
  logic               req_l1d;
  logic [1:0]         grant;
  logic               busy_i;
  logic               busy_d;

  // A flush in IDLE only masks the L1I request for that one cycle.
  assign req_l1i = read_L1I_L2 & ~flush_I;
  assign req_l1d = read_L1D_L2 | write_L1D_L2;

  l1_l2_rr_pick u_pick (
    .req_l1i_i    (req_l1i),
    .req_l1d_i    (req_l1d),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;   // L1I wins the first tie after reset
      tag_q        <= '0;
      index_q      <= '0;
      cmd_wr_q     <= 1'b0;
      swallow_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      cmd_wr_q     <= cmd_wr_d;
      swallow_q    <= swallow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    index_d      = index_q;
    cmd_wr_d     = cmd_wr_q;
    swallow_d    = swallow_q;
    case (state_q)
      IDLE: begin
        swallow_d = 1'b0;
        if (grant[REQ_I]) begin
          state_d      = BUSY_I;
          last_grant_d = REQ_I;
          tag_d        = tag_L1I_L2;
          index_d      = index_L1I_L2;
          cmd_wr_d     = 1'b0;
        end else if (grant[REQ_D]) begin
          state_d      = BUSY_D;
          last_grant_d = REQ_D;
          tag_d        = tag_L1D_L2;
          index_d      = index_L1D_L2;
          // Write wins if the L1D illegally raises both commands.
          cmd_wr_d     = write_L1D_L2;
        end
      end
      BUSY_I: begin
        // The L2 transaction must still complete; only the reply is dropped.
        swallow_d = swallow_q | flush_I;
        if (ready_L2_L1) state_d = GAP;
      end
      BUSY_D: begin
        if (ready_L2_L1) state_d = GAP;
      end
      GAP: begin
        // One dead cycle lets the requester drop its held request.
        swallow_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_i = (state_q == BUSY_I);
  assign busy_d = (state_q == BUSY_D);

  // Command drops combinationally with the ready pulse so L2 never sees
  // a stale request in the completion cycle.
  assign read_L1_L2       = (busy_i | (busy_d & ~cmd_wr_q)) & ~ready_L2_L1;
  assign write_L1_L2      = busy_d & cmd_wr_q & ~ready_L2_L1;
  assign tag_L1_L2        = tag_q;
  assign index_L1_L2      = index_q;
  assign write_data_L1_L2 = (busy_d & cmd_wr_q) ? write_data_L1D_L2 : '0;

  // A flush arriving in the completion cycle also suppresses the reply.
  assign ready_L2_L1I     = busy_i & ready_L2_L1 & ~(swallow_q | flush_I);
  assign ready_L2_L1D     = busy_d & ready_L2_L1;
  assign read_data_L2_L1I = busy_i ? read_data_L2_L1 : '0;
  assign read_data_L2_L1D = busy_d ? read_data_L2_L1 : '0;

`ifdef L1_L2_ARB_PERF_CNT_EN
  logic [15:0] cnt_i_q;
  logic [15:0] cnt_d_q;
  logic        fire_i;
  logic        fire_d;

  assign fire_i = (state_q == IDLE) & grant[REQ_I];
  assign fire_d = (state_q == IDLE) & grant[REQ_D];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_i_q <= '0;
      cnt_d_q <= '0;
    end else begin
      if (fire_i && (cnt_i_q != 16'hFFFF)) cnt_i_q <= cnt_i_q + 16'd1;
      if (fire_d && (cnt_d_q != 16'hFFFF)) cnt_d_q <= cnt_d_q + 16'd1;
    end
  end

  assign grant_cnt_I = cnt_i_q;
  assign grant_cnt_D = cnt_d_q;
`else
  assign grant_cnt_I = '0;
  assign grant_cnt_D = '0;
`endif

endmodule

`default_nettype wire
